// File: rtl/pc_stack_sequencer.sv
// Program counter with conditional/relative branching and a
// hardware return-address stack with sticky fault reporting.
module pc_stack_sequencer #(
  parameter int ADDR_W      = 12,
  parameter int STACK_DEPTH = 8,
  parameter int REL_W       = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               en_i,
  input  logic [2:0]                         op_i,
  input  logic                               cond_i,
  input  logic [ADDR_W-1:0]                  target_i,
  input  logic [REL_W-1:0]                   rel_off_i,
  input  logic                               clr_fault_i,
  output logic [ADDR_W-1:0]                  pc_o,
  output logic [ADDR_W-1:0]                  stack_top_o,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth_o,
  output logic                               stack_full_o,
  output logic                               stack_empty_o,
  output logic                               fault_o,
  output logic [1:0]                         fault_code_o
);

  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam int IW = $clog2(STACK_DEPTH);

  typedef enum logic [2:0] {
    OP_INC   = 3'b000,
    OP_JMP   = 3'b001,
    OP_JMPC  = 3'b010,
    OP_BRREL = 3'b011,
    OP_CALL  = 3'b100,
    OP_RET   = 3'b101,
    OP_HOLD  = 3'b110,
    OP_SCLR  = 3'b111
  } op_e;

  localparam logic [1:0] F_NONE  = 2'b00;
  localparam logic [1:0] F_OVER  = 2'b01;
  localparam logic [1:0] F_UNDER = 2'b10;

  op_e               op;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, rel_ext, top;
  logic [DW-1:0]     depth_q, depth_d;
  logic              fault_q, fault_d;
  logic [1:0]        code_q, code_d, new_f;
  logic              push, full, empty;
  logic [IW-1:0]     wr_idx, rd_idx;
  logic [ADDR_W-1:0] mem_q [STACK_DEPTH];

  assign op      = op_e'(op_i);
  assign pc_inc  = pc_q + 1'b1;
  assign rel_ext = ADDR_W'($signed(rel_off_i));
  assign full    = (depth_q == DW'(STACK_DEPTH));
  assign empty   = (depth_q == '0);
  assign wr_idx  = IW'(depth_q);
  assign rd_idx  = IW'(depth_q - 1'b1);
  assign top     = empty ? '0 : mem_q[rd_idx];

  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    push    = 1'b0;
    new_f   = F_NONE;
    if (en_i) begin
      unique case (op)
        OP_INC:   pc_d = pc_inc;
        OP_JMP:   pc_d = target_i;
        OP_JMPC:  pc_d = cond_i ? target_i : pc_inc;
        OP_BRREL: pc_d = cond_i ? pc_q + rel_ext : pc_inc;
        OP_CALL: begin
          if (!full) begin
            push    = 1'b1;
            depth_d = depth_q + 1'b1;
            pc_d    = target_i;
          end else begin
            pc_d  = pc_inc;
            new_f = F_OVER;
          end
        end
        OP_RET: begin
          if (!empty) begin
            pc_d    = top;
            depth_d = depth_q - 1'b1;
          end else begin
            pc_d  = pc_inc;
            new_f = F_UNDER;
          end
        end
        OP_HOLD:  pc_d = pc_q;
        OP_SCLR: begin
          depth_d = '0;
          pc_d    = pc_inc;
        end
      endcase
    end
  end

  // A fresh fault beats a simultaneous clear; otherwise first code sticks
  always_comb begin
    fault_d = fault_q;
    code_d  = code_q;
    if (new_f != F_NONE) begin
      fault_d = 1'b1;
      if (clr_fault_i || !fault_q) code_d = new_f;
    end else if (clr_fault_i) begin
      fault_d = 1'b0;
      code_d  = F_NONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= '0;
      depth_q <= '0;
      fault_q <= 1'b0;
      code_q  <= F_NONE;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      fault_q <= fault_d;
      code_q  <= code_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_idx] <= pc_inc;
  end

  assign pc_o          = pc_q;
  assign stack_top_o   = top;
  assign depth_o       = depth_q;
  assign stack_full_o  = full;
  assign stack_empty_o = empty;
  assign fault_o       = fault_q;
  assign fault_code_o  = code_q;

endmodule

// File: tb/tb_pc_stack_sequencer.sv
// Directed bench for pc_stack_sequencer with a queue-based
// reference model compared on every falling edge.
module tb_pc_stack_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [2:0]  op;
  logic        cond;
  logic [11:0] target;
  logic [7:0]  rel;
  logic        clr;
  logic [11:0] pc, top;
  logic [3:0]  depth;
  logic        full, empty, fault;
  logic [1:0]  code;

  int checks   = 0;
  int failures = 0;

  int          m_pc;
  logic [11:0] m_stk[$];
  bit          m_fault;
  int          m_code;

  pc_stack_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .en_i         (en),
    .op_i         (op),
    .cond_i       (cond),
    .target_i     (target),
    .rel_off_i    (rel),
    .clr_fault_i  (clr),
    .pc_o         (pc),
    .stack_top_o  (top),
    .depth_o      (depth),
    .stack_full_o (full),
    .stack_empty_o(empty),
    .fault_o      (fault),
    .fault_code_o (code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pc = 0;
    m_stk.delete();
    m_fault = 0;
    m_code = 0;
  endfunction

  function automatic void model_step(input bit e, input int o, input bit c,
                                     input int t, input int r, input bit cl);
    int nf = 0;
    if (e) begin
      case (o)
        0: m_pc = m_pc + 1;
        1: m_pc = t;
        2: m_pc = c ? t : m_pc + 1;
        3: m_pc = c ? m_pc + (r >= 128 ? r - 256 : r) : m_pc + 1;
        4: if (m_stk.size() < 8) begin
             m_stk.push_back(12'((m_pc + 1) & 'hFFF));
             m_pc = t;
           end else begin
             m_pc = m_pc + 1;
             nf = 1;
           end
        5: if (m_stk.size() > 0) m_pc = m_stk.pop_back();
           else begin
             m_pc = m_pc + 1;
             nf = 2;
           end
        6: ;
        default: begin
          m_stk.delete();
          m_pc = m_pc + 1;
        end
      endcase
      m_pc = m_pc & 'hFFF;
    end
    if (nf != 0) begin
      if (cl || !m_fault) m_code = nf;
      m_fault = 1;
    end else if (cl) begin
      m_fault = 0;
      m_code = 0;
    end
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      chk("pc", int'(pc), m_pc);
      chk("stack_top", int'(top),
          m_stk.size() > 0 ? int'(m_stk[m_stk.size()-1]) : 0);
      chk("depth", int'(depth), m_stk.size());
      chk("stack_full", int'(full), int'(m_stk.size() == 8));
      chk("stack_empty", int'(empty), int'(m_stk.size() == 0));
      chk("fault", int'(fault), int'(m_fault));
      chk("fault_code", int'(code), m_code);
    end
  end

  task automatic step(input bit e, input int o, input bit c = 0,
                      input int t = 0, input int r = 0, input bit cl = 0);
    en     = e;
    op     = 3'(o);
    cond   = c;
    target = 12'(t);
    rel    = 8'(r);
    clr    = cl;
    @(posedge clk);
    model_step(e, o, c, t, r, cl);
    #1;
  endtask

  initial begin
    model_reset();
    rst = 1'b1; en = 0; op = 0; cond = 0;
    target = 0; rel = 0; clr = 0;
    #3;
    chk("rst_pc", int'(pc), 0);
    chk("rst_depth", int'(depth), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_top", int'(top), 0);
    chk("rst_fault", int'({fault, code}), 0);
    #4 rst = 1'b0;

    repeat (5) step(1, 0);
    chk("inc5", int'(pc), 5);
    step(1, 1, 0, 'hFFF);
    step(1, 0);
    chk("inc_wrap", int'(pc), 0);

    step(1, 1, 0, 'h010);
    step(1, 2, 0, 'h200);
    chk("jmpc_nt", int'(pc), 'h011);
    step(1, 2, 1, 'h200);
    chk("jmpc_t", int'(pc), 'h200);

    step(1, 1, 0, 'h100);
    step(1, 3, 1, 0, 'hFC);
    chk("brrel_neg", int'(pc), 'h0FC);
    step(1, 1, 0, 'h005);
    step(1, 3, 1, 0, 'hF0);
    chk("brrel_wrap", int'(pc), 'hFF5);
    step(1, 3, 0, 0, 'h10);
    chk("brrel_nt", int'(pc), 'hFF6);
    step(1, 6);
    chk("hold", int'(pc), 'hFF6);

    step(1, 1, 0, 'h020);
    step(1, 4, 0, 'h100);
    step(1, 4, 0, 'h200);
    step(1, 4, 0, 'h300);
    chk("nest_depth", int'(depth), 3);
    chk("nest_top", int'(top), 'h201);
    step(1, 5);
    chk("ret1", int'(pc), 'h201);
    step(1, 5);
    chk("ret2", int'(pc), 'h101);
    step(1, 5);
    chk("ret3", int'(pc), 'h021);
    chk("ret_empty", int'(empty), 1);
    chk("ret_fault", int'(fault), 0);

    step(1, 4, 0, 'h050);
    repeat (7) step(1, 4, 0, 'h050);
    chk("full8_depth", int'(depth), 8);
    chk("full8_flag", int'(full), 1);
    chk("full8_nofault", int'(fault), 0);
    step(1, 4, 0, 'h050);
    chk("ovf_pc", int'(pc), 'h051);
    chk("ovf_fault", int'({fault, code}), 'b101);
    step(1, 7);
    chk("sclr_depth", int'(depth), 0);
    step(1, 5);
    chk("sticky_code", int'(code), 1);
    step(1, 5, 0, 0, 0, 1);
    chk("clr_vs_new", int'({fault, code}), 'b110);
    step(0, 4, 0, 'h300, 0, 1);
    chk("clr_en0", int'({fault, code}), 0);

    step(1, 1, 0, 'hFFF);
    step(1, 4, 0, 'h123);
    chk("push_wrap", int'(top), 0);
    step(1, 5);
    chk("ret_wrap", int'(pc), 0);

    step(1, 5);
    repeat (4) step(1, 4, 0, 'h3A7);
    chk("pre_rst_depth", int'(depth), 4);
    chk("pre_rst_pc", int'(pc), 'h3A7);
    chk("pre_rst_fault", int'(fault), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_pc", int'(pc), 0);
    chk("async_depth", int'(depth), 0);
    chk("async_fault", int'({fault, code}), 0);
    model_reset();
    #1 rst = 1'b0;
    repeat (3) step(0, 4, 0, 'h456);
    chk("en0_pc", int'(pc), 0);
    chk("en0_depth", int'(depth), 0);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
